// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: edge-detected push on rx_done,
// first-word-fall-through read, fill level, sticky overflow. Optional: UART_RX_FIFO_OVF_CNT_EN.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    input  logic              rd_en,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow
`ifdef UART_RX_FIFO_OVF_CNT_EN
    ,
    output logic [7:0]        ovf_cnt
`endif
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic              rx_done_q, rx_done_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic push, pop, push_ok, drop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign rd_data  = mem_q[rd_ptr_q];

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        push       = rx_done & ~rx_done_q;
        pop        = rd_en & ~empty;
        push_ok    = push & (~full | pop);
        drop       = push & full & ~pop;
        rx_done_d  = rx_done;
        wr_ptr_d   = push_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        // A drop in the clearing cycle takes priority so no overflow event is lost.
        overflow_d = drop | (overflow_q & ~ovf_clr);
    end

    // NOTE: sequential blocks use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_done_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rx_done_q  <= rx_done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array is reset on purpose so rd_data reads zero out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            // On full+pop wr_ptr equals rd_ptr; the read port still sees the old byte this cycle.
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

`ifdef UART_RX_FIFO_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_clr) begin
            ovf_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_cnt_q <= 8'd0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model, scoreboard of popped bytes,
// directed scenarios followed by randomized traffic. Honours UART_RX_FIFO_OVF_CNT_EN.
module tb_uart_rx_fifo;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] rx_data;
    logic              rx_done;
    logic              rd_en;
    logic              ovf_clr;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
`ifdef UART_RX_FIFO_OVF_CNT_EN
    logic [7:0]        ovf_cnt;
`endif

    uart_rx_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rd_en    (rd_en),
        .ovf_clr  (ovf_clr),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
`ifdef UART_RX_FIFO_OVF_CNT_EN
        ,
        .ovf_cnt  (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, plus sticky flag and drop counter.
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] exp_q[$];
    bit                m_ovf;
    int                m_ovf_cnt;
    bit                m_prev_done;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_ovf       = 1'b0;
        m_ovf_cnt   = 0;
        m_prev_done = 1'b0;
    endtask

    // Apply one cycle of inputs (called at posedge+1), then advance the model at the edge.
    task automatic step(input bit done, input logic [DATA_W-1:0] data, input bit rd, input bit clr);
        bit push, pop, drop;
        rx_done = done;
        rx_data = data;
        rd_en   = rd;
        ovf_clr = clr;
        push    = done && !m_prev_done;
        pop     = rd && (mq.size() > 0);
        if (pop) exp_q.push_back(mq[0]);
        @(posedge clk);
        drop = push && (mq.size() == DEPTH) && !pop;
        if (pop) void'(mq.pop_front());
        if (push && !drop) mq.push_back(data);
        m_ovf = drop || (m_ovf && !clr);
        if (clr) m_ovf_cnt = drop ? 1 : 0;
        else if (drop && m_ovf_cnt < 255) m_ovf_cnt++;
        m_prev_done = done;
        #1;
    endtask

    task automatic push_byte(input logic [DATA_W-1:0] b);
        step(1'b1, b, 1'b0, 1'b0);
        step(1'b0, b, 1'b0, 1'b0);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    // Monitor: compares state against the model and scores every byte the DUT hands over.
    always @(negedge clk) begin
        check("count", count, mq.size());
        check("empty", empty, mq.size() == 0);
        check("full", full, mq.size() == DEPTH);
        check("overflow", overflow, m_ovf);
`ifdef UART_RX_FIFO_OVF_CNT_EN
        check("ovf_cnt", ovf_cnt, m_ovf_cnt);
`endif
        if (mq.size() > 0) check("head", rd_data, mq[0]);
        if (reset && rd_en && !empty) begin
            if (exp_q.size() == 0) check("sb_unexpected_pop", 1, 0);
            else check("sb_pop_data", rd_data, exp_q.pop_front());
        end
    end

    initial begin
        reset   = 1'b0;
        rx_data = '0;
        rx_done = 1'b0;
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
        model_reset();
        #22 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_rd_data", rd_data, 0);

        // rd_en on an empty FIFO is ignored
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("idle_rd_count", count, 0);

        // three pulses, then three pops in order
        push_byte(8'h41);
        push_byte(8'h42);
        push_byte(8'h43);
        check("three_count", count, 3);
        check("three_head", rd_data, 8'h41);
        pop_n(3);
        check("three_empty", empty, 1);

        // long rx_done level pushes exactly once
        for (int i = 0; i < 10; i++) step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("level_count", count, 1);
        pop_n(1);

        // fill, then overflow drop of 0xAA
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        check("fill_full", full, 1);
        push_byte(8'hAA);
        check("drop_overflow", overflow, 1);
        check("drop_count", count, DEPTH);
`ifdef UART_RX_FIFO_OVF_CNT_EN
        check("drop_ovf_cnt", ovf_cnt, 1);
`endif
        pop_n(DEPTH);
        check("drain_empty", empty, 1);
        step(1'b0, '0, 1'b0, 1'b1);

        // full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        step(1'b1, 8'h99, 1'b1, 1'b0);
        check("pp_count", count, DEPTH);
        check("pp_head", rd_data, 8'h01);
        pop_n(DEPTH - 1);
        check("pp_last", rd_data, 8'h99);
        pop_n(1);

        // overflow clear collides with a new drop, then clears alone
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h20 + i));
        push_byte(8'hAA);
        step(1'b1, 8'hBB, 1'b0, 1'b1);
        check("clr_drop_ovf", overflow, 1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("clr_alone_ovf", overflow, 0);
        pop_n(DEPTH);

        // reset in the middle of a fill
        for (int i = 0; i < 7; i++) push_byte(8'(8'h70 + i));
        check("mid_count", count, 7);
        reset = 1'b0;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_rd_data", rd_data, 0);
        model_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        // randomized traffic, alternating drain-heavy and fill-heavy phases
        for (int i = 0; i < 3000; i++) begin
            bit done, rd, clr;
            done = 1'($urandom_range(0, 1));
            rd   = ((i / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 15) == 0);
            step(done, 8'($urandom), rd, clr);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        pop_n(DEPTH + 2);
        check("final_empty", empty, 1);
        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
